// File: rtl/servgrid_wb_arbiter_if.sv
// Bus bundle between the SERV requesters, the arbiter and the shared Wishbone slave.
// The arbiter connects through the slave modport; the requester/slave environment uses master.
interface servgrid_wb_arbiter_if #(
    parameter int unsigned nreq = 16
);
    logic [nreq*32-1:0] i_req_adr;
    logic [nreq*32-1:0] i_req_dat;
    logic [nreq*4-1:0]  i_req_sel;
    logic [nreq-1:0]    i_req_we;
    logic [nreq-1:0]    i_req_stb;
    logic [31:0]        o_req_rdt;
    logic [nreq-1:0]    o_req_ack;
    logic [nreq-1:0]    o_req_err;
    logic [31:0]        o_wb_adr;
    logic [31:0]        o_wb_dat;
    logic [3:0]         o_wb_sel;
    logic               o_wb_we;
    logic               o_wb_stb;
    logic [31:0]        i_wb_rdt;
    logic               i_wb_ack;
    logic [nreq-1:0]    o_grant;
    logic               o_busy;

    modport master (
        output i_req_adr, i_req_dat, i_req_sel, i_req_we, i_req_stb, i_wb_rdt, i_wb_ack,
        input  o_req_rdt, o_req_ack, o_req_err, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we,
               o_wb_stb, o_grant, o_busy
    );

    modport slave (
        input  i_req_adr, i_req_dat, i_req_sel, i_req_we, i_req_stb, i_wb_rdt, i_wb_ack,
        output o_req_rdt, o_req_ack, o_req_err, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we,
               o_wb_stb, o_grant, o_busy
    );
endinterface

// File: rtl/servgrid_wb_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave among nreq SERV cores, with an
// optional stall timeout that terminates a granted access with ack+err.
module servgrid_wb_arbiter #(
    parameter int unsigned nreq    = 16,
    parameter int unsigned timeout = 255
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst,
    servgrid_wb_arbiter_if.slave bus
);
    localparam int unsigned   gw      = (nreq > 1) ? $clog2(nreq) : 1;
    localparam int unsigned   tw      = (timeout > 0) ? $clog2(timeout + 1) : 1;
    localparam logic [tw-1:0] tc_last = (timeout > 0) ? tw'(timeout - 1) : '0;
    localparam logic [gw-1:0] lg_rst  = gw'(nreq - 1);
    localparam bit            tmo_en  = (timeout != 0);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [gw-1:0]   g_q, g_d, lg_q, lg_d, sel;
    logic [tw-1:0]   tc_q, tc_d;
    logic            found;
    logic [31:0]     adr_g, dat_g;
    logic [3:0]      sel_g;
    logic            we_g, stb_g, tmo;
    logic [nreq-1:0] onehot_g;

    // First pending requester after lg, wrapping around to index 0.
    always_comb begin
        found = 1'b0;
        sel   = lg_q;
        for (int r = 0; r < nreq; r++) begin
            if (!found && bus.i_req_stb[r] && (gw'(r) > lg_q)) begin
                found = 1'b1;
                sel   = gw'(r);
            end
        end
        for (int r = 0; r < nreq; r++) begin
            if (!found && bus.i_req_stb[r] && (gw'(r) <= lg_q)) begin
                found = 1'b1;
                sel   = gw'(r);
            end
        end
    end

    always_comb begin
        adr_g    = '0;
        dat_g    = '0;
        sel_g    = '0;
        we_g     = 1'b0;
        stb_g    = 1'b0;
        onehot_g = '0;
        for (int r = 0; r < nreq; r++) begin
            if (g_q == gw'(r)) begin
                adr_g       = bus.i_req_adr[32*r +: 32];
                dat_g       = bus.i_req_dat[32*r +: 32];
                sel_g       = bus.i_req_sel[4*r +: 4];
                we_g        = bus.i_req_we[r];
                stb_g       = bus.i_req_stb[r];
                onehot_g[r] = 1'b1;
            end
        end
    end

    // Expiry loses to both a slave ack and an abort in the same cycle.
    assign tmo = tmo_en && (state_q == StBusy) && !bus.i_wb_ack && stb_g && (tc_q == tc_last);

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        lg_d    = lg_q;
        tc_d    = tc_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StBusy;
                    g_d     = sel;
                    lg_d    = sel;
                    tc_d    = '0;
                end
            end
            StBusy: begin
                if (bus.i_wb_ack || !stb_g || tmo) begin
                    state_d = StIdle;
                end else begin
                    tc_d = tc_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        bus.o_wb_adr  = '0;
        bus.o_wb_dat  = '0;
        bus.o_wb_sel  = '0;
        bus.o_wb_we   = 1'b0;
        bus.o_wb_stb  = 1'b0;
        bus.o_req_ack = '0;
        bus.o_req_err = '0;
        bus.o_req_rdt = '0;
        bus.o_grant   = '0;
        bus.o_busy    = 1'b0;
        if (state_q == StBusy) begin
            bus.o_busy   = 1'b1;
            bus.o_grant  = onehot_g;
            bus.o_wb_adr = adr_g;
            bus.o_wb_dat = dat_g;
            bus.o_wb_sel = sel_g;
            bus.o_wb_we  = we_g;
            bus.o_wb_stb = stb_g && !tmo;
            if (bus.i_wb_ack) begin
                bus.o_req_ack = onehot_g;
                bus.o_req_rdt = bus.i_wb_rdt;
            end else if (tmo) begin
                bus.o_req_ack = onehot_g;
                bus.o_req_err = onehot_g;
            end
        end
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q <= StIdle;
            g_q     <= '0;
            lg_q    <= lg_rst;
            tc_q    <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            lg_q    <= lg_d;
            tc_q    <= tc_d;
        end
    end
endmodule

// File: tb/tb_servgrid_wb_arbiter.sv
// Scoreboard bench for servgrid_wb_arbiter: directed requester traffic against a
// programmable-latency slave model; a monitor checks every ack against the queue.
module tb_servgrid_wb_arbiter;
    localparam int NREQ = 16;
    localparam int TMO  = 8;

    typedef struct {
        logic [NREQ-1:0] ack;
        logic            err;
        logic [31:0]     rdt;
        int              bc;
        int              gap;
    } exp_t;

    logic wb_clk = 1'b0;
    logic wb_rst = 1'b1;

    servgrid_wb_arbiter_if #(.nreq(NREQ)) bus ();

    servgrid_wb_arbiter #(.nreq(NREQ), .timeout(TMO)) dut (
        .wb_clk (wb_clk),
        .wb_rst (wb_rst),
        .bus    (bus)
    );

    always #5 wb_clk = ~wb_clk;

    exp_t            sb[$];
    exp_t            e;
    int              n_vec    = 0;
    int              n_bad    = 0;
    int              ack_at   = 1;
    logic [31:0]     rdt_base = '0;
    int              busy_cnt = 0;
    int              cyc      = 0;
    int              last_ack = 0;
    int              ack_cnt [NREQ] = '{default: 0};
    int              seen    [NREQ] = '{default: 0};
    logic [NREQ-1:0] hold     = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Slave model: acks in the ack_at-th BUSY cycle (0 = never), rdt derived from address.
    initial begin
        bus.i_wb_ack = 1'b0;
        bus.i_wb_rdt = '0;
        forever begin
            @(posedge wb_clk);
            #1;
            if (bus.o_busy) busy_cnt++;
            else busy_cnt = 0;
            bus.i_wb_ack = bus.o_busy && (ack_at != 0) && (busy_cnt == ack_at);
            bus.i_wb_rdt = rdt_base ^ bus.o_wb_adr;
        end
    end

    always @(negedge wb_clk) begin
        #1;
        cyc++;
        if (bus.o_req_ack != '0) begin
            for (int r = 0; r < NREQ; r++) if (bus.o_req_ack[r]) ack_cnt[r]++;
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_ack: got ack %h err %h, want none", bus.o_req_ack,
                         bus.o_req_err);
            end else begin
                e = sb.pop_front();
                check("ack_vec", 32'(bus.o_req_ack), 32'(e.ack));
                check("err_vec", 32'(bus.o_req_err), e.err ? 32'(e.ack) : 32'h0);
                check("rdt", bus.o_req_rdt, e.rdt);
                check("busy_cycle", busy_cnt, e.bc);
                if (e.gap != 0) check("ack_gap", cyc - last_ack, e.gap);
            end
            last_ack = cyc;
        end else if (bus.o_req_err != '0) begin
            n_vec++;
            n_bad++;
            $display("FAIL err_without_ack: got err %h, want 0", bus.o_req_err);
        end
    end

    // Requesters release stb the cycle after their ack unless told to hold it.
    task automatic tick();
        @(posedge wb_clk);
        #2;
        for (int r = 0; r < NREQ; r++) begin
            if (seen[r] != ack_cnt[r]) begin
                seen[r] = ack_cnt[r];
                if (!hold[r]) bus.i_req_stb[r] = 1'b0;
            end
        end
    endtask

    task automatic wait_empty(input int bound);
        for (int i = 0; i < bound && sb.size() != 0; i++) tick();
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic push(input int r, input logic err, input logic [31:0] rdt, input int bc,
                        input int gap);
        exp_t x;
        x.ack = '0;
        x.ack[r] = 1'b1;
        x.err = err;
        x.rdt = rdt;
        x.bc  = bc;
        x.gap = gap;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        wb_rst = 1'b1;
        tick();
        tick();
        wb_rst = 1'b0;
        tick();
    endtask

    initial begin
        bus.i_req_adr = '0;
        bus.i_req_dat = '0;
        bus.i_req_sel = '1;
        bus.i_req_we  = '0;
        bus.i_req_stb = '0;
        #2;
        check("rst_busy", 32'(bus.o_busy), 32'h0);
        check("rst_grant", 32'(bus.o_grant), 32'h0);
        check("rst_wb_stb", 32'(bus.o_wb_stb), 32'h0);
        check("rst_ack", 32'(bus.o_req_ack), 32'h0);
        do_reset();

        // Single zero-wait read from requester 3.
        ack_at   = 1;
        rdt_base = 32'hDEAD_BEAF;
        bus.i_req_adr[3*32 +: 32] = 32'h40;
        push(3, 1'b0, 32'hDEAD_BEEF, 1, 0);
        bus.i_req_stb[3] = 1'b1;
        tick();
        check("single_adr", bus.o_wb_adr, 32'h40);
        check("single_grant", 32'(bus.o_grant), 32'h0008);
        check("single_stb", 32'(bus.o_wb_stb), 32'h1);
        wait_empty(20);
        tick();
        check("single_idle", 32'(bus.o_busy), 32'h0);

        // All requesters at once: order 0..15, one grant every 2 cycles.
        do_reset();
        rdt_base = 32'h1234_0000;
        for (int r = 0; r < NREQ; r++) begin
            bus.i_req_adr[r*32 +: 32] = 32'(r << 4);
            push(r, 1'b0, 32'h1234_0000 | 32'(r << 4), 1, (r == 0) ? 0 : 2);
        end
        bus.i_req_stb = '1;
        wait_empty(100);
        tick();
        check("all_idle", 32'(bus.o_busy), 32'h0);

        // Fairness between two continuous requesters.
        do_reset();
        rdt_base = '0;
        bus.i_req_adr[0*32 +: 32] = 32'h100;
        bus.i_req_adr[5*32 +: 32] = 32'h500;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) push(0, 1'b0, 32'h100, 1, (i == 0) ? 0 : 2);
            else push(5, 1'b0, 32'h500, 1, 2);
        end
        hold = 16'h0021;
        bus.i_req_stb[0] = 1'b1;
        bus.i_req_stb[5] = 1'b1;
        wait_empty(60);
        bus.i_req_stb[0] = 1'b0;
        bus.i_req_stb[5] = 1'b0;
        hold = '0;
        tick();
        tick();
        check("fair_idle", 32'(bus.o_busy), 32'h0);

        // Timeout: slave never acks a write from requester 2.
        ack_at   = 0;
        rdt_base = 32'hFFFF_FFFF;
        bus.i_req_adr[2*32 +: 32] = 32'h200;
        bus.i_req_dat[2*32 +: 32] = 32'hCAFE_F00D;
        bus.i_req_sel[2*4 +: 4]   = 4'h3;
        bus.i_req_we[2]           = 1'b1;
        push(2, 1'b1, 32'h0, TMO, 0);
        bus.i_req_stb[2] = 1'b1;
        tick();
        check("tmo_dat", bus.o_wb_dat, 32'hCAFE_F00D);
        check("tmo_we_sel", {27'h0, bus.o_wb_we, bus.o_wb_sel}, 32'h13);
        for (int i = 0; i < TMO - 2; i++) tick();
        check("tmo_stb_c7", 32'(bus.o_wb_stb), 32'h1);
        tick();
        check("tmo_stb_c8", 32'(bus.o_wb_stb), 32'h0);
        check("tmo_err_c8", 32'(bus.o_req_err), 32'h0004);
        check("tmo_rdt_c8", bus.o_req_rdt, 32'h0);
        tick();
        check("tmo_idle", 32'(bus.o_busy), 32'h0);
        bus.i_req_we[2] = 1'b0;

        // Slave ack lands in the expiry cycle: normal completion, no err.
        ack_at   = TMO;
        rdt_base = 32'h5555_0000;
        bus.i_req_adr[6*32 +: 32] = 32'h600;
        push(6, 1'b0, 32'h5555_0600, TMO, 0);
        bus.i_req_stb[6] = 1'b1;
        for (int i = 0; i < TMO; i++) tick();
        check("bnd_stb_c8", 32'(bus.o_wb_stb), 32'h1);
        check("bnd_err_c8", 32'(bus.o_req_err), 32'h0);
        tick();
        check("bnd_idle", 32'(bus.o_busy), 32'h0);

        // Abort: requester 9 drops stb while BUSY.
        ack_at = 0;
        bus.i_req_adr[9*32 +: 32] = 32'h900;
        bus.i_req_stb[9] = 1'b1;
        tick();
        tick();
        tick();
        bus.i_req_stb[9] = 1'b0;
        #1;
        check("abort_busy", 32'(bus.o_busy), 32'h1);
        check("abort_stb", 32'(bus.o_wb_stb), 32'h0);
        check("abort_ack_err", {bus.o_req_ack, bus.o_req_err}, 32'h0);
        tick();
        check("abort_idle", 32'(bus.o_busy), 32'h0);
        tick();
        check("abort_no_regrant", 32'(bus.o_busy), 32'h0);

        // Reset mid-access, then lowest-index pending requester wins.
        bus.i_req_adr[11*32 +: 32] = 32'hB00;
        bus.i_req_stb[11] = 1'b1;
        tick();
        tick();
        check("rstmid_busy", 32'(bus.o_grant), 32'h0800);
        bus.i_req_adr[4*32 +: 32] = 32'h400;
        bus.i_req_adr[7*32 +: 32] = 32'h700;
        bus.i_req_stb[4] = 1'b1;
        bus.i_req_stb[7] = 1'b1;
        wb_rst = 1'b1;
        #1;
        check("rstmid_stb", 32'(bus.o_wb_stb), 32'h0);
        check("rstmid_busy_drop", 32'(bus.o_busy), 32'h0);
        check("rstmid_grant", 32'(bus.o_grant), 32'h0);
        ack_at   = 1;
        rdt_base = '0;
        push(4, 1'b0, 32'h400, 1, 0);
        push(7, 1'b0, 32'h700, 1, 2);
        push(11, 1'b0, 32'hB00, 1, 2);
        tick();
        tick();
        wb_rst = 1'b0;
        tick();
        check("post_rst_grant", 32'(bus.o_grant), 32'h0010);
        wait_empty(40);
        tick();
        tick();
        check("final_idle", 32'(bus.o_busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by t=%0t, want finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
